// File: rtl/mux_rr_sched_pkg.sv
// mux_rr_sched_pkg: shared defaults, FSM encoding and one-hot helper for the round-robin mux scheduler
package mux_rr_sched_pkg;
  localparam int DEF_N        = 16;
  localparam int DEF_SEL_W    = 4;
  localparam int DEF_HOLD_MAX = 8;
  localparam int DEF_CNT_W    = 3;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  function automatic int onehot_idx(input logic [63:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 64; i++) if (v[i]) r |= i;
    return r;
  endfunction
endpackage

// File: rtl/mux_rr_sched_rr_pick.sv
// rr_pick: combinational round-robin winner search starting at ptr, wrapping modulo N
module rr_pick #(
  parameter int N     = 16,
  parameter int SEL_W = 4
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] win_idx
);
  logic [N-1:0] rot;
  logic [SEL_W-1:0] off;
  assign rot = N'({req, req} >> ptr);
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = SEL_W'(i);
  end
  assign found   = |req;
  assign win_idx = ptr + off;
endmodule

// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin scheduler driving the shared 16:1 mux select with bounded grant tenure
module mux_rr_sched
  import mux_rr_sched_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int SEL_W    = DEF_SEL_W,
  parameter int HOLD_MAX = DEF_HOLD_MAX,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [SEL_W-1:0] sel,
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [CNT_W-1:0] tenure
);
  state_t state;
  logic [SEL_W-1:0] ptr, pick_ptr, win_idx;
  logic found, rel;
  // while busy, the hand-over search starts just past the grantee, which is the post-release ptr
  assign pick_ptr = (state == BUSY) ? sel + SEL_W'(1) : ptr;
  assign rel      = !en || !req[sel] || tenure == CNT_W'(HOLD_MAX - 1);
  rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .found  (found),
    .win_idx(win_idx)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      sel         <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      tenure      <= '0;
    end else if (state == IDLE || rel) begin
      if (state == BUSY) ptr <= sel + SEL_W'(1);
      tenure <= '0;
      if (en && found) begin
        state       <= BUSY;
        sel         <= win_idx;
        grant       <= {{(N-1){1'b0}}, 1'b1} << win_idx;
        grant_valid <= 1'b1;
      end else begin
        state       <= IDLE;
        grant       <= '0;
        grant_valid <= 1'b0;
      end
    end else begin
      tenure <= tenure + CNT_W'(1);
    end
  end
  a_valid : assert property (@(posedge clk) disable iff (!rst_n) grant_valid == |grant);
  a_sel : assert property (@(posedge clk) disable iff (!rst_n)
    grant_valid |-> sel == SEL_W'(onehot_idx(64'(grant))));
endmodule

// File: tb/tb_mux_rr_sched.sv
// tb_mux_rr_sched: directed self-checking bench for the round-robin mux scheduler
module tb_mux_rr_sched;
  logic clk = 1'b0;
  logic rst_n, en;
  logic [15:0] req;
  logic [3:0] sel;
  logic [15:0] grant;
  logic grant_valid;
  logic [2:0] tenure;
  int checks = 0;
  int errors = 0;
  int seq [4] = '{0, 8, 15, 0};

  mux_rr_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req        (req),
    .sel        (sel),
    .grant      (grant),
    .grant_valid(grant_valid),
    .tenure     (tenure)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_grant(input string tag, input int s, input int t);
    chk({tag, "_sel"}, 32'(sel), 32'(s));
    chk({tag, "_grant"}, 32'(grant), 32'(16'h1 << s));
    chk({tag, "_gv"}, 32'(grant_valid), 32'd1);
    chk({tag, "_ten"}, 32'(tenure), 32'(t));
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    req   = '0;
    tick(2);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_gv", 32'(grant_valid), 32'd0);
    chk("rst_ten", 32'(tenure), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_grant", 32'(grant), 32'd0);
    // single requester: full tenure then bubble-free re-grant to itself
    req = 16'h0008;
    for (int t = 0; t < 8; t++) begin
      tick();
      chk_grant("single", 3, t);
    end
    tick();
    chk_grant("regrant", 3, 0);
    // async reset in mid-grant clears outputs before the next edge
    #2;
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_gv", 32'(grant_valid), 32'd0);
    chk("arst_sel", 32'(sel), 32'd0);
    tick();
    rst_n = 1'b1;
    // rotation 0 -> 8 -> 15 -> wrap to 0, eight cycles each
    req = 16'h8101;
    for (int g = 0; g < 4; g++)
      for (int t = 0; t < 8; t++) begin
        tick();
        chk_grant("rot", seq[g], t);
      end
    // early release: req[0] gone, ptr=1 picks 1; drop req[1] at tenure 3
    req = 16'h0006;
    tick();
    chk_grant("early_a", 1, 0);
    tick(3);
    chk_grant("early_b", 1, 3);
    req = 16'h0004;
    tick();
    chk_grant("early_c", 2, 0);
    // enable gating
    req = 16'h0020;
    tick();
    chk_grant("en_a", 5, 0);
    en = 1'b0;
    tick();
    chk("en_off_grant", 32'(grant), 32'd0);
    chk("en_off_gv", 32'(grant_valid), 32'd0);
    chk("en_off_sel", 32'(sel), 32'd5);
    req = 16'h0060;
    tick();
    chk("en_glitch", 32'(grant), 32'd0);
    en = 1'b1;
    tick();
    chk_grant("en_on", 6, 0);
    // req[sel] drops on the expiry edge: one release, ptr=7 picks 7 (not 5)
    tick(7);
    chk_grant("sim_a", 6, 7);
    req = 16'h00A0;
    tick();
    chk_grant("sim_b", 7, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
